tas: RTL and testbench

TAS -- requirements
Module: tas

---
 rtl/tas.sv | 231 +++++++++++++++++++++++
 tb/tb_tas.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tas.sv
// rtl/tas.sv - serial temperature packet averager feeding a RAM writer through an async FIFO
//
// Purpose: receives a LSB-first serial byte stream in the clk_50 domain, frames
// it into 5-byte packets (header + 4 payload bytes), averages the payload of
// temperature packets (header A5 or C3) and hands each average across to the
// clk_2 domain through a 4-entry gray-pointer FIFO. The clk_2 side writes each
// result to RAM at a decrementing address starting at 12'h7FF.
//
// Build option: TAS_ROUND_EN - average rounds half up instead of truncating.
//
// Ports:
//   clk_50       in   serial receive clock
//   clk_2        in   RAM write clock, asynchronous to clk_50
//   reset_n      in   active-low reset, synchronised separately into each domain
//   serial_data  in   serial byte stream, bit 0 first
//   data_ena     in   serial_data carries a valid bit
//   ram_wr_n     out  active-low RAM write strobe (clk_2)
//   ram_addr     out  RAM write address (clk_2)
//   ram_data     out  RAM write data (clk_2)
`timescale 1ns/1ps

module tas (
  input  logic        clk_50,
  input  logic        clk_2,
  input  logic        reset_n,
  input  logic        serial_data,
  input  logic        data_ena,
  output logic        ram_wr_n,
  output logic [11:0] ram_addr,
  output logic [10:0] ram_data
);

  // ---------------------------------------------------------------- clk_50
  logic rst50_meta_q, rst50_n_q;

  always_ff @(posedge clk_50) begin
    rst50_meta_q <= reset_n;
    rst50_n_q    <= rst50_meta_q;
  end

  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [9:0]  acc_q, acc_d;
  logic        is_temp_q, is_temp_d;
  logic        push_q, push_d;
  logic [10:0] avg_q, avg_d;
  logic [7:0]  byte_val;
  logic        byte_done;
  logic [9:0]  sum_next;
  logic [9:0]  sum_adj;

  // The byte completing this cycle includes the bit being sampled now.
  assign byte_val  = {serial_data, shift_q[7:1]};
  assign byte_done = data_ena && (bit_cnt_q == 3'd7);
  assign sum_next  = acc_q + {2'b00, byte_val};

`ifdef TAS_ROUND_EN
  // Max 4*255+2 = 1022 still fits the 10-bit accumulator width.
  assign sum_adj = sum_next + 10'd2;
`else
  assign sum_adj = sum_next;
`endif

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    is_temp_d  = is_temp_q;
    push_d     = 1'b0;
    avg_d      = avg_q;

    if (data_ena) begin
      shift_d   = byte_val;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      bit_cnt_d = 3'd0;
    end

    if (byte_done) begin
      if (byte_cnt_q == 3'd0) begin
        // Only byte slot 0 is ever examined as a header.
        is_temp_d  = (byte_val == 8'hA5) || (byte_val == 8'hC3);
        acc_d      = 10'd0;
        byte_cnt_d = 3'd1;
      end else if (byte_cnt_q == 3'd4) begin
        acc_d      = sum_next;
        byte_cnt_d = 3'd0;
        push_d     = is_temp_q;
        avg_d      = 11'(sum_adj >> 2);
      end else begin
        acc_d      = sum_next;
        byte_cnt_d = byte_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst50_n_q) begin
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 3'd0;
      acc_q      <= 10'd0;
      is_temp_q  <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      is_temp_q  <= is_temp_d;
      push_q     <= push_d;
    end
  end

  always_ff @(posedge clk_50) begin
    shift_q <= shift_d;
    avg_q   <= avg_d;
  end

  // ------------------------------------------------------- FIFO write side
  logic [10:0] fifo_mem [4];
  logic [2:0]  wbin_q, wgray_q, rgray_meta_q, rgray_sync_q;
  logic [2:0]  wbin_inc;
  logic        fifo_full, fifo_wr;
  logic [2:0]  rbin_q, rgray_q;

  // Full when the write pointer is exactly one lap ahead: top two gray bits differ.
  assign fifo_full = (wgray_q == {~rgray_sync_q[2:1], rgray_sync_q[0]});
  assign fifo_wr   = push_q && !fifo_full;
  assign wbin_inc  = wbin_q + 3'd1;

  always_ff @(posedge clk_50) begin
    if (!rst50_n_q) begin
      wbin_q       <= 3'd0;
      wgray_q      <= 3'd0;
      rgray_meta_q <= 3'd0;
      rgray_sync_q <= 3'd0;
    end else begin
      rgray_meta_q <= rgray_q;
      rgray_sync_q <= rgray_meta_q;
      if (fifo_wr) begin
        wbin_q  <= wbin_inc;
        wgray_q <= wbin_inc ^ (wbin_inc >> 1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (fifo_wr) fifo_mem[wbin_q[1:0]] <= avg_q;
  end

  // ----------------------------------------------------------------- clk_2
  logic rst2_meta_q, rst2_n_q;

  always_ff @(posedge clk_2) begin
    rst2_meta_q <= reset_n;
    rst2_n_q    <= rst2_meta_q;
  end

  logic [2:0]  wgray_meta_q, wgray_sync_q;
  logic [2:0]  rbin_inc;
  logic        fifo_empty;
  logic [11:0] ram_addr_q;
  logic [10:0] ram_data_q;
  logic        pop;
  logic        addr_step;

  assign fifo_empty = (rgray_q == wgray_sync_q);
  assign rbin_inc   = rbin_q + 3'd1;

  // Encoding walks 00->01->11->10 so each step flips one bit and the STROBE
  // decode driving ram_wr_n cannot glitch.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_STROBE = 2'b11,
    S_HOLD   = 2'b10
  } wr_state_e;

  wr_state_e state_q, state_d;

  always_ff @(posedge clk_2) begin
    if (!rst2_n_q) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // SETUP gives a cycle of stable address/data before the strobe, HOLD a
  // cycle after it; the address only moves on leaving HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_wr_n  = (state_q != S_STROBE);
    pop       = (state_q == S_IDLE) && !fifo_empty;
    addr_step = (state_q == S_HOLD);
  end

  always_ff @(posedge clk_2) begin
    if (!rst2_n_q) begin
      wgray_meta_q <= 3'd0;
      wgray_sync_q <= 3'd0;
      rbin_q       <= 3'd0;
      rgray_q      <= 3'd0;
      ram_addr_q   <= 12'h7FF;
      ram_data_q   <= 11'd0;
    end else begin
      wgray_meta_q <= wgray_q;
      wgray_sync_q <= wgray_meta_q;
      if (pop) begin
        ram_data_q <= fifo_mem[rbin_q[1:0]];
        rbin_q     <= rbin_inc;
        rgray_q    <= rbin_inc ^ (rbin_inc >> 1);
      end
      if (addr_step) begin
        ram_addr_q <= (ram_addr_q == 12'h000) ? 12'h7FF : ram_addr_q - 12'd1;
      end
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;

endmodule

// File: tb/tb_tas.sv
// tb/tb_tas.sv - self-checking bench for tas with a packet-level reference model
`timescale 1ns/1ps

module tb_tas;

  logic        clk_50 = 1'b0;
  logic        clk_2  = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial_data = 1'b0;
  logic        data_ena = 1'b0;
  logic        ram_wr_n;
  logic [11:0] ram_addr;
  logic [10:0] ram_data;

  tas dut (
    .clk_50      (clk_50),
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .ram_wr_n    (ram_wr_n),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data)
  );

  always #10 clk_50 = ~clk_50;
  initial begin
    #7;
    forever #250 clk_2 = ~clk_2;
  end

  int n_chk  = 0;
  int n_pass = 0;

  int got_addr [$];
  int got_data [$];
  int exp_data [$];
  int model_addr = 'h7FF;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Write monitor: records every strobe and checks the strobe/address/data protocol.
  logic        prev_wr_n = 1'b1;
  logic [11:0] prev_addr = 12'h0;
  logic [10:0] prev_data = 11'h0;

  always @(negedge clk_2) begin
    if (reset_n) begin
      if (!ram_wr_n) begin
        check("wr_gap_before", int'(prev_wr_n), 1);
        check("setup_addr", int'(ram_addr), int'(prev_addr));
        check("setup_data", int'(ram_data), int'(prev_data));
        got_addr.push_back(int'(ram_addr));
        got_data.push_back(int'(ram_data));
      end else if (!prev_wr_n) begin
        check("hold_addr", int'(ram_addr), int'(got_addr[$]));
        check("hold_data", int'(ram_data), int'(got_data[$]));
      end
    end
    prev_wr_n = ram_wr_n;
    prev_addr = ram_addr;
    prev_data = ram_data;
  end

  // Reference model: a packet either yields its payload average or nothing.
  task automatic model_pkt(input logic [39:0] p);
    int sum;
    if (p[39:32] == 8'hA5 || p[39:32] == 8'hC3) begin
      sum = int'(p[31:24]) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
`ifdef TAS_ROUND_EN
      exp_data.push_back((sum + 2) / 4);
`else
      exp_data.push_back(sum / 4);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      data_ena = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50);
      data_ena    = 1'b1;
      serial_data = b[i];
    end
    idle(gap);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      data_ena    = 1'b1;
      serial_data = 1'($urandom_range(0, 1));
    end
    idle(1);
  endtask

  task automatic send_pkt(input logic [39:0] p, input int gap);
    model_pkt(p);
    for (int b = 0; b < 5; b++) send_byte(p[39-8*b -: 8], gap);
  endtask

  // Waits for the expected writes, then compares data and addresses in order.
  // In burst mode the FIFO may drop the newest results, so any in-order
  // prefix of at least four is acceptable.
  task automatic drain(input int burst);
    int n_exp;
    n_exp = exp_data.size();
    for (int t = 0; t < 150 && got_data.size() < n_exp; t++) @(negedge clk_2);
    repeat (12) @(negedge clk_2);
    if (burst != 0) begin
      check("burst_min_writes", int'(got_data.size() >= 4), 1);
      check("burst_max_writes", int'(got_data.size() <= n_exp), 1);
    end else begin
      check("write_count", got_data.size(), n_exp);
    end
    for (int i = 0; i < got_data.size() && i < n_exp; i++) begin
      check("write_data", got_data[i], exp_data[i]);
      check("write_addr", got_addr[i], model_addr);
      model_addr = (model_addr == 0) ? 'h7FF : model_addr - 1;
    end
    got_addr.delete();
    got_data.delete();
    exp_data.delete();
  endtask

  task automatic check_reset_outputs();
    check("reset_wr_n", int'(ram_wr_n), 1);
    check("reset_addr", int'(ram_addr), 'h7FF);
    check("reset_data", int'(ram_data), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] hdr;
    logic [39:0] pkt;

    reset_n = 1'b0;
    repeat (6) @(negedge clk_2);
    check_reset_outputs();
    reset_n = 1'b1;
    repeat (3) @(negedge clk_2);

    // Single packet with inter-byte gaps.
    send_pkt({8'hA5, 8'h3A, 8'h55, 8'h43, 8'h3C}, 5);
    idle(5);
    drain(0);

    // Burst with 1-cycle gaps.
    send_pkt({8'hA5, 8'd10, 8'd20, 8'd30, 8'd40}, 1);
    idle(5);
    drain(0);

    // Slow start, burst across the packet boundary, late final byte.
    model_pkt({8'hA5, 8'h02, 8'h04, 8'h06, 8'h08});
    model_pkt({8'hA5, 8'h10, 8'h12, 8'h14, 8'h16});
    send_byte(8'hA5, 20);
    send_byte(8'h02, 20);
    send_byte(8'h04, 20);
    send_byte(8'h06, 20);
    send_byte(8'h08, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    send_byte(8'h12, 0);
    send_byte(8'h14, 60);
    send_byte(8'h16, 2);
    idle(5);
    drain(0);

    // Non-temperature packets with embedded header values, then a valid one.
    send_pkt({8'hC2, 8'hA5, 8'hC3, 8'hA5, 8'hC3}, 1);
    send_pkt({8'hA1, 8'hA5, 8'hC3, 8'hC3, 8'hA5}, 0);
    send_pkt({8'hA5, 8'd127, 8'd127, 8'd127, 8'd127}, 2);
    idle(5);
    drain(0);

    // Full-scale payload and header C3.
    send_pkt({8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFE}, 0);
    idle(5);
    drain(0);

    // Reset in the middle of a packet.
    send_byte(8'hA5, 1);
    send_byte(8'd10, 1);
    send_byte(8'd20, 1);
    reset_n = 1'b0;
    repeat (8) @(negedge clk_2);
    check_reset_outputs();
    reset_n = 1'b1;
    repeat (3) @(negedge clk_2);
    model_addr = 'h7FF;
    send_pkt({8'hA5, 8'd1, 8'd2, 8'd3, 8'd7}, 1);
    idle(5);
    drain(0);

    // Randomised packets with occasional discarded partial bytes.
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0:       hdr = 8'hA5;
        1:       hdr = 8'hC3;
        default: hdr = 8'($urandom_range(0, 255));
      endcase
      pkt = {hdr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 1) == 1) send_bits($urandom_range(1, 7));
      send_pkt(pkt, $urandom_range(0, 3));
      idle(5);
      drain(0);
    end

    // Five temperature packets back to back at full rate.
    for (int k = 0; k < 5; k++) begin
      pkt = {8'hA5, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      send_pkt(pkt, 0);
    end
    idle(5);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
